// File: rtl/countdown_ctrl.sv
// countdown_ctrl
//   Sequencing controller for the countdown timer datapath. Converts raw
//   start/pause/restart button levels into one-cycle edge events, runs the
//   IDLE/RUN/PAUSED/DONE state machine, and owns the down-counter and the
//   seconds prescaler.
//
// Parameters
//   WIDTH     preset/count width in bits
//   TICK_DIV  clk cycles per count decrement (>= 2)
//
// Ports
//   clk        in   1      system clock, rising edge
//   reset      in   1      asynchronous, active-high; clears all state
//   in         in   WIDTH  preset value, unsigned seconds
//   start_con  in   1      start/resume button level
//   pause      in   1      pause toggle button level
//   restart    in   1      abort-to-idle button level
//   count      out  WIDTH  current remaining count (registered)
//   state      out  3      0=IDLE 1=RUN 2=PAUSED 3=DONE (registered)
//   tick       out  1      one-cycle pulse on each decrement (registered)
//   led        out  1      high while state is DONE (registered)
module countdown_ctrl #(
  parameter int WIDTH    = 6,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             start_con,
  input  logic             pause,
  input  logic             restart,
  output logic [WIDTH-1:0] count,
  output logic [2:0]       state,
  output logic             tick,
  output logic             led
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_PAUSED = 3'd2,
    S_DONE   = 3'd3
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [PW-1:0]    presc_reg;
  logic             tick_reg;
  logic             led_reg;
  logic             start_q;
  logic             pause_q;
  logic             restart_q;

  logic ev_start;
  logic ev_pause;
  logic ev_restart;
  logic presc_wrap;
  logic in_zero;

  // Rising-edge detection: a held button produces a single event.
  assign ev_start   = start_con & ~start_q;
  assign ev_pause   = pause     & ~pause_q;
  assign ev_restart = restart   & ~restart_q;

  assign presc_wrap = (presc_reg == PRESC_LAST);
  assign in_zero    = (in == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      presc_reg <= '0;
      tick_reg  <= 1'b0;
      led_reg   <= 1'b0;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      start_q   <= start_con;
      pause_q   <= pause;
      restart_q <= restart;
      tick_reg  <= 1'b0;

      if (ev_restart) begin
        // Count is left alone here; the next IDLE cycle reloads it from in.
        state_reg <= S_IDLE;
        presc_reg <= '0;
        led_reg   <= 1'b0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            count_reg <= in;
            led_reg   <= 1'b0;
            if (ev_start) begin
              presc_reg <= '0;
              if (in_zero) begin
                state_reg <= S_DONE;
                led_reg   <= 1'b1;
              end else begin
                state_reg <= S_RUN;
              end
            end
          end

          S_RUN: begin
            if (presc_wrap) begin
              presc_reg <= '0;
              tick_reg  <= 1'b1;
              // Reaching zero ends the run even if a pause arrives now;
              // the <= also keeps a zero count from wrapping.
              if (count_reg <= WIDTH'(1)) begin
                count_reg <= '0;
                state_reg <= S_DONE;
                led_reg   <= 1'b1;
              end else begin
                count_reg <= count_reg - 1'b1;
                if (ev_pause) begin
                  state_reg <= S_PAUSED;
                end
              end
            end else begin
              presc_reg <= presc_reg + 1'b1;
              if (ev_pause) begin
                state_reg <= S_PAUSED;
              end
            end
          end

          S_PAUSED: begin
            // Count and prescaler hold; either button resumes exactly once.
            if (ev_start || ev_pause) begin
              state_reg <= S_RUN;
            end
          end

          S_DONE: begin
            count_reg <= '0;
            led_reg   <= 1'b1;
            if (ev_start) begin
              count_reg <= in;
              presc_reg <= '0;
              if (!in_zero) begin
                state_reg <= S_RUN;
                led_reg   <= 1'b0;
              end
            end
          end

          default: begin
            // Illegal encodings fall back to a clean IDLE.
            state_reg <= S_IDLE;
            presc_reg <= '0;
            led_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count = count_reg;
  assign state = state_reg;
  assign tick  = tick_reg;
  assign led   = led_reg;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl
//   Self-checking bench for countdown_ctrl with TICK_DIV=4 and a 40ns clock.
//   Inputs change on the falling edge; the expected outputs for that cycle
//   are queued at the same time and popped/compared 1ns after the rising edge.
module tb_countdown_ctrl;

  localparam int WIDTH    = 6;
  localparam int TICK_DIV = 4;

  localparam logic [2:0] ST_I = 3'd0;
  localparam logic [2:0] ST_R = 3'd1;
  localparam logic [2:0] ST_P = 3'd2;
  localparam logic [2:0] ST_D = 3'd3;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in;
  logic             start_con;
  logic             pause;
  logic             restart;
  logic [WIDTH-1:0] count;
  logic [2:0]       state;
  logic             tick;
  logic             led;

  countdown_ctrl #(
    .WIDTH   (WIDTH),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in),
    .start_con(start_con),
    .pause    (pause),
    .restart  (restart),
    .count    (count),
    .state    (state),
    .tick     (tick),
    .led      (led)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] in;
    logic             s;
    logic             p;
    logic             r;
    logic [2:0]       st;
    logic [WIDTH-1:0] cnt;
    logic             tk;
    logic             ld;
  } vec_t;

  typedef struct {
    logic [2:0]       st;
    logic [WIDTH-1:0] cnt;
    logic             tk;
    logic             ld;
  } exp_t;

  vec_t table_q[$];
  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [2:0] st,
                       input logic [WIDTH-1:0] cnt, input logic tk, input logic ld);
    n_vec++;
    if (state !== st || count !== cnt || tick !== tk || led !== ld) begin
      n_miss++;
      $display("FAIL %s: got state=%0d count=%0d tick=%0b led=%0b, want state=%0d count=%0d tick=%0b led=%0b",
               name, state, count, tick, led, st, cnt, tk, ld);
    end
  endtask

  task automatic add(input logic [WIDTH-1:0] i, input logic s, input logic p, input logic r,
                     input logic [2:0] st, input logic [WIDTH-1:0] cnt,
                     input logic tk, input logic ld);
    vec_t v;
    v.in = i; v.s = s; v.p = p; v.r = r;
    v.st = st; v.cnt = cnt; v.tk = tk; v.ld = ld;
    table_q.push_back(v);
  endtask

  // Drive one cycle of inputs, queue what should appear after the next
  // rising edge, then pop and compare.
  task automatic step(input string name, input logic [WIDTH-1:0] i,
                      input logic s, input logic p, input logic r,
                      input logic [2:0] st, input logic [WIDTH-1:0] cnt,
                      input logic tk, input logic ld);
    exp_t e;
    @(negedge clk);
    in = i; start_con = s; pause = p; restart = r;
    e.st = st; e.cnt = cnt; e.tk = tk; e.ld = ld;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      check(name, e.st, e.cnt, e.tk, e.ld);
    end
  endtask

  initial begin
    reset = 1'b1; in = 6'd10; start_con = 1'b0; pause = 1'b0; restart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", ST_I, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Idle tracking, full run from 3, held-start single event, reload from DONE.
    add(10, 0,0,0, ST_I, 10, 0, 0);
    add( 3, 0,0,0, ST_I,  3, 0, 0);
    add( 3, 1,0,0, ST_R,  3, 0, 0);
    add( 3, 0,0,0, ST_R,  3, 0, 0);
    add(50, 0,0,0, ST_R,  3, 0, 0);
    add(50, 0,0,0, ST_R,  3, 0, 0);
    add(50, 0,0,0, ST_R,  2, 1, 0);
    add(50, 0,0,0, ST_R,  2, 0, 0);
    add(50, 1,0,0, ST_R,  2, 0, 0);
    add(50, 0,0,0, ST_R,  2, 0, 0);
    add(50, 0,0,0, ST_R,  1, 1, 0);
    for (int k = 0; k < 3; k++) add(50, 0,0,0, ST_R, 1, 0, 0);
    add(50, 0,0,0, ST_D,  0, 1, 1);
    add(50, 0,0,0, ST_D,  0, 0, 1);
    add( 0, 0,0,1, ST_I,  0, 0, 0);
    add( 0, 0,0,0, ST_I,  0, 0, 0);
    add( 0, 1,0,0, ST_D,  0, 0, 1);
    for (int k = 0; k < 9; k++) add(5, 1,0,0, ST_D, 0, 0, 1);
    add( 2, 0,0,0, ST_D,  0, 0, 1);
    add( 2, 1,0,0, ST_R,  2, 0, 0);
    for (int k = 0; k < 3; k++) add(2, 0,0,0, ST_R, 2, 0, 0);
    add( 2, 0,0,0, ST_R,  1, 1, 0);
    for (int k = 0; k < 3; k++) add(2, 0,0,0, ST_R, 1, 0, 0);
    add( 2, 0,0,0, ST_D,  0, 1, 1);

    for (int k = 0; k < table_q.size(); k++) begin
      step($sformatf("table[%0d]", k), table_q[k].in, table_q[k].s, table_q[k].p, table_q[k].r,
           table_q[k].st, table_q[k].cnt, table_q[k].tk, table_q[k].ld);
    end

    // Pause, long hold, resume from the held prescaler, start+pause resume.
    step("p_start",  10, 1,0,0, ST_R, 10, 0, 0);
    for (int k = 0; k < 3; k++) step("p_run", 10, 0,0,0, ST_R, 10, 0, 0);
    step("p_tick",   10, 0,0,0, ST_R,  9, 1, 0);
    step("p_run1",   10, 0,0,0, ST_R,  9, 0, 0);
    step("p_pause",  10, 0,1,0, ST_P,  9, 0, 0);
    for (int k = 0; k < 20; k++) step("p_hold", 10, 0,0,0, ST_P, 9, 0, 0);
    step("p_resume", 10, 1,0,0, ST_R,  9, 0, 0);
    step("p_rest",   10, 0,0,0, ST_R,  9, 0, 0);
    step("p_tick2",  10, 0,0,0, ST_R,  8, 1, 0);
    step("p_run2",   10, 0,0,0, ST_R,  8, 0, 0);
    step("p_pause2", 10, 0,1,0, ST_P,  8, 0, 0);
    step("p_hold2",  10, 0,0,0, ST_P,  8, 0, 0);
    step("p_both",   10, 1,1,0, ST_R,  8, 0, 0);
    step("p_run3",   10, 0,0,0, ST_R,  8, 0, 0);
    step("p_tick3",  10, 0,0,0, ST_R,  7, 1, 0);

    // Restart at count 7, reload from in, restart beats start.
    step("r_restart", 21, 0,0,1, ST_I,  7, 0, 0);
    step("r_reload",  21, 0,0,0, ST_I, 21, 0, 0);
    step("r_both",    21, 1,0,1, ST_I, 21, 0, 0);
    step("r_idle",    21, 0,0,0, ST_I, 21, 0, 0);

    // Pause on the 1->0 tick: DONE wins.
    step("z_start", 1, 1,0,0, ST_R, 1, 0, 0);
    for (int k = 0; k < 3; k++) step("z_run", 1, 0,0,0, ST_R, 1, 0, 0);
    step("z_pause_tick", 1, 0,1,0, ST_D, 0, 1, 1);
    step("z_done",       1, 0,0,0, ST_D, 0, 0, 1);

    // Pause on a 2->1 tick: decrement applies and PAUSED is entered.
    step("t_start", 2, 1,0,0, ST_R, 2, 0, 0);
    for (int k = 0; k < 3; k++) step("t_run", 2, 0,0,0, ST_R, 2, 0, 0);
    step("t_pause_tick", 2, 0,1,0, ST_P, 1, 1, 0);
    step("t_paused",     2, 0,0,0, ST_P, 1, 0, 0);
    step("t_resume",     2, 0,1,0, ST_R, 1, 0, 0);
    for (int k = 0; k < 3; k++) step("t_run2", 2, 0,0,0, ST_R, 1, 0, 0);
    step("t_done",       2, 0,0,0, ST_D, 0, 1, 1);

    // Asynchronous reset while tick is high in RUN.
    step("a_start", 5, 1,0,0, ST_R, 5, 0, 0);
    for (int k = 0; k < 3; k++) step("a_run", 5, 0,0,0, ST_R, 5, 0, 0);
    step("a_tick", 5, 0,0,0, ST_R, 4, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    check("a_async_reset", ST_I, 6'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step("a_after", 5, 0,0,0, ST_I, 5, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
